stack_alu_unit: RTL and testbench

- Parametrised successor to the fixed 16-bit stack/ALU/immediate-mux integration.
- Wraps a WIDTH×DEPTH register stack and ALU behind a valid/ready command interface.
- Adds depth tracking, full/empty flags, stack over/underflow and illegal-op detection, and a per-command response pulse.
- Sits between the instruction decoder and the stack datapath of the stack processor.

---
 rtl/stack_alu_unit.sv | 217 +++++++++++++++++++++
 tb/tb_stack_alu_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_unit.sv
// stack_alu_unit: WIDTH x DEPTH register stack with ALU behind a valid/ready
// command port, with a one-cycle response pulse and status flags.
// Ports: CLK, reset (async, active-low); cmd_valid/cmd_ready/cmd_op/cmd_imm;
//   rsp_valid/rsp_status {illegal,underflow,overflow_stack}/alu_ovf;
//   err_sticky; top/next (entries 0/1); depth; full; empty.
// Option: define STACK_ALU_MUL_EN to enable opcode 12 as MUL.
module stack_alu_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  output logic [2:0]       rsp_status,
  output logic             alu_ovf,
  output logic             err_sticky,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
`ifdef STACK_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;
`endif

  state_t           state, state_n;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] stk   [DEPTH];
  logic [WIDTH-1:0] stk_n [DEPTH];
  logic [CNT_W-1:0] depth_q, depth_n, need;
  logic             full_q, empty_q;
  logic [2:0]       st_q, st_n;
  logic             ovf_q, ovf_n, sticky_q;
  logic             ill, under, over, grow, bin, ok, ovf;
  logic [WIDTH-1:0] a, b, res;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cmd_valid) state_n = EXEC;
      EXEC: state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // a = next, b = top; binary ops compute next OP top
  always_comb begin
    stk_n   = stk;
    depth_n = depth_q;
    need    = '0;
    ill     = 1'b0;
    grow    = 1'b0;
    bin     = 1'b0;
    ovf     = 1'b0;
    a       = stk[1];
    b       = stk[0];
    res     = '0;
    case (op_q)
      OP_NOP:  grow = 1'b0;
      OP_PUSH: grow = 1'b1;
      OP_POP:  need = CNT_W'(1);
      OP_DUP: begin
        need = CNT_W'(1);
        grow = 1'b1;
      end
      OP_SWAP: need = CNT_W'(2);
      OP_ADD: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a + b;
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) &&
               (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a - b;
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) &&
               (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a & b;
      end
      OP_OR: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a | b;
      end
      OP_XOR: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a ^ b;
      end
      OP_NOT:  need = CNT_W'(1);
      OP_SHL: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a << b[3:0];
      end
`ifdef STACK_ALU_MUL_EN
      OP_MUL: begin
        need = CNT_W'(2);
        bin  = 1'b1;
        res  = a * b;
      end
`endif
      default: ill = 1'b1;
    endcase

    // priority keeps exactly one status bit per failed command
    under = !ill && (depth_q < need);
    over  = !ill && !under && grow && full_q;
    st_n  = {ill, under, over};
    ok    = (st_n == 3'b000);
    ovf_n = ok && ovf;

    if (ok) begin
      if (bin) begin
        stk_n[0] = res;
        for (int i = 1; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
        stk_n[DEPTH-1] = '0;
        depth_n = depth_q - CNT_W'(1);
      end else begin
        case (op_q)
          OP_PUSH, OP_DUP: begin
            for (int i = 1; i < DEPTH; i++) stk_n[i] = stk[i-1];
            stk_n[0] = (op_q == OP_PUSH) ? imm_q : stk[0];
            depth_n  = depth_q + CNT_W'(1);
          end
          OP_POP: begin
            for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
            stk_n[DEPTH-1] = '0;
            depth_n = depth_q - CNT_W'(1);
          end
          OP_SWAP: begin
            stk_n[0] = stk[1];
            stk_n[1] = stk[0];
          end
          OP_NOT: stk_n[0] = ~stk[0];
          default: stk_n[0] = stk[0];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      imm_q    <= '0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      depth_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      st_q     <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        imm_q <= cmd_imm;
      end
      if (state == EXEC) begin
        stk      <= stk_n;
        depth_q  <= depth_n;
        full_q   <= (depth_n == CNT_W'(DEPTH));
        empty_q  <= (depth_n == '0);
        st_q     <= st_n;
        ovf_q    <= ovf_n;
        sticky_q <= sticky_q | (|st_n);
      end
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_status = st_q;
  assign alu_ovf    = ovf_q;
  assign err_sticky = sticky_q;
  // entries past depth are kept zero, so absent top/next read as 0
  assign top        = stk[0];
  assign next       = stk[1];
  assign depth      = depth_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_stack_alu_unit.sv
// tb_stack_alu_unit: randomized and directed bench for stack_alu_unit,
// checked against a queue-based stack model (WIDTH=16, DEPTH=8).
module tb_stack_alu_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_imm = '0;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic        alu_ovf;
  logic        err_sticky;
  logic [15:0] top_w, next_w;
  logic [3:0]  depth_w;
  logic        full_w, empty_w;

  int checks = 0;
  int errors = 0;

  stack_alu_unit #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .alu_ovf(alu_ovf), .err_sticky(err_sticky),
    .top(top_w), .next(next_w), .depth(depth_w),
    .full(full_w), .empty(empty_w)
  );

  always #5 CLK = ~CLK;

  // reference model: queue front is the stack top
  logic [15:0] m_q[$];
  logic        m_sticky;

  function automatic void model(input logic [3:0] op,
                                input logic [15:0] imm,
                                output logic [2:0] st,
                                output logic ov);
    logic [15:0] x, y, r;
    int s;
    st = 3'b000;
    ov = 1'b0;
    r = 16'h0;
    case (op)
      4'd0: ;
      4'd1: if (m_q.size() == 8) st = 3'b001; else m_q.push_front(imm);
      4'd2: if (m_q.size() < 1) st = 3'b010; else void'(m_q.pop_front());
      4'd3: if (m_q.size() < 1) st = 3'b010;
            else if (m_q.size() == 8) st = 3'b001;
            else m_q.push_front(m_q[0]);
      4'd4: if (m_q.size() < 2) st = 3'b010;
            else begin x = m_q[0]; m_q[0] = m_q[1]; m_q[1] = x; end
      4'd10: if (m_q.size() < 1) st = 3'b010; else m_q[0] = ~m_q[0];
`ifndef STACK_ALU_MUL_EN
      4'd12: st = 3'b100;
`endif
      4'd13, 4'd14, 4'd15: st = 3'b100;
      default: begin
        if (m_q.size() < 2) st = 3'b010;
        else begin
          y = m_q.pop_front();
          x = m_q.pop_front();
          case (op)
            4'd5: begin
              s = $signed(x) + $signed(y);
              r = x + y;
              ov = (s > 32767) || (s < -32768);
            end
            4'd6: begin
              s = $signed(x) - $signed(y);
              r = x - y;
              ov = (s > 32767) || (s < -32768);
            end
            4'd7: r = x & y;
            4'd8: r = x | y;
            4'd9: r = x ^ y;
            4'd11: r = 16'(32'(x) << y[3:0]);
            default: r = 16'(32'(x) * 32'(y));
          endcase
          m_q.push_front(r);
        end
      end
    endcase
    if (st != 3'b000) m_sticky = 1'b1;
  endfunction

  function automatic logic [15:0] m_top();
    return (m_q.size() > 0) ? m_q[0] : 16'h0;
  endfunction

  function automatic logic [15:0] m_next();
    return (m_q.size() > 1) ? m_q[1] : 16'h0;
  endfunction

  // observations captured by send()
  logic        o_rdy_x, o_rv_x, o_rv, o_ovf, o_full, o_empty, o_stk;
  logic        o_rv_a, o_rdy_a;
  logic [2:0]  o_st, o_st_a;
  logic [15:0] o_top, o_next;
  logic [3:0]  o_depth;

  task automatic send(input logic [3:0] op, input logic [15:0] imm);
    int n = 0;
    @(negedge CLK);
    while (!cmd_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_ready_timeout ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom);
    cmd_imm   = 16'($urandom);
    o_rdy_x = cmd_ready;
    o_rv_x  = rsp_valid;
    @(posedge CLK); #1;
    o_rv    = rsp_valid;
    o_st    = rsp_status;
    o_ovf   = alu_ovf;
    o_top   = top_w;
    o_next  = next_w;
    o_depth = depth_w;
    o_full  = full_w;
    o_empty = empty_w;
    o_stk   = err_sticky;
    @(posedge CLK); #1;
    o_rv_a  = rsp_valid;
    o_rdy_a = cmd_ready;
    o_st_a  = rsp_status;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    m_q.delete();
    m_sticky = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({top_w, next_w} !== 32'h0) begin
      errors++;
      $display("FAIL reset_top_next got %h/%h want 0/0", top_w, next_w);
    end
    checks++;
    if ({depth_w, empty_w, full_w} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_depth_flags got %0d e%b f%b want 0 e1 f0",
               depth_w, empty_w, full_w);
    end
    checks++;
    if ({rsp_valid, rsp_status, alu_ovf, err_sticky, cmd_ready}
        !== 7'b0_000_001) begin
      errors++;
      $display("FAIL reset_outputs got rv%b st%b ov%b es%b rdy%b want 0/000/0/0/1",
               rsp_valid, rsp_status, alu_ovf, err_sticky, cmd_ready);
    end
  endtask

  task automatic test_sub();
    do_reset();
    send(4'd1, 16'd3);
    send(4'd1, 16'd5);
    send(4'd6, 16'h1234);
    checks++;
    if ({o_rdy_x, o_rv_x, o_rv} !== 3'b001) begin
      errors++;
      $display("FAIL sub_timing got rdyx%b rvx%b rv%b want 0 0 1",
               o_rdy_x, o_rv_x, o_rv);
    end
    checks++;
    if ({o_st, o_ovf, o_top, o_depth} !== {3'b000, 1'b0, 16'hFFFE, 4'd1}) begin
      errors++;
      $display("FAIL sub_result got st%b ov%b top%h d%0d want 000 0 fffe 1",
               o_st, o_ovf, o_top, o_depth);
    end
    checks++;
    if ({o_rv_a, o_rdy_a} !== 2'b01) begin
      errors++;
      $display("FAIL sub_after got rv%b rdy%b want 0 1", o_rv_a, o_rdy_a);
    end
  endtask

  task automatic test_add_ovf();
    do_reset();
    send(4'd1, 16'h7FFF);
    send(4'd1, 16'h0001);
    send(4'd5, 16'h0);
    checks++;
    if ({o_top, o_ovf, o_st} !== {16'h8000, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL add_ovf got top%h ov%b st%b want 8000 1 000",
               o_top, o_ovf, o_st);
    end
    send(4'd10, 16'h0);
    checks++;
    if ({o_top, o_ovf, o_depth} !== {16'h7FFF, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL not_after_add got top%h ov%b d%0d want 7fff 0 1",
               o_top, o_ovf, o_depth);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) send(4'd1, 16'(i + 16'h100));
    checks++;
    if ({o_full, o_empty, o_depth, o_stk} !== {1'b1, 1'b0, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL full_flag got f%b e%b d%0d es%b want 1 0 8 0",
               o_full, o_empty, o_depth, o_stk);
    end
    send(4'd1, 16'hDEAD);
    checks++;
    if ({o_st, o_depth, o_top, o_stk} !== {3'b001, 4'd8, 16'h0107, 1'b1}) begin
      errors++;
      $display("FAIL push_overflow got st%b d%0d top%h es%b want 001 8 0107 1",
               o_st, o_depth, o_top, o_stk);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    send(4'd2, 16'h0);
    checks++;
    if ({o_st, o_depth, o_empty} !== {3'b010, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL pop_empty got st%b d%0d e%b want 010 0 1",
               o_st, o_depth, o_empty);
    end
    send(4'd1, 16'd7);
    send(4'd5, 16'h0);
    checks++;
    if ({o_st, o_depth, o_top, o_next} !== {3'b010, 4'd1, 16'd7, 16'd0}) begin
      errors++;
      $display("FAIL add_depth1 got st%b d%0d top%h nx%h want 010 1 0007 0000",
               o_st, o_depth, o_top, o_next);
    end
    send(4'd4, 16'h0);
    checks++;
    if ({o_st, o_top} !== {3'b010, 16'd7}) begin
      errors++;
      $display("FAIL swap_depth1 got st%b top%h want 010 0007", o_st, o_top);
    end
    send(4'd13, 16'h0);
    checks++;
    if ({o_st, o_depth} !== {3'b100, 4'd1}) begin
      errors++;
      $display("FAIL illegal_13 got st%b d%0d want 100 1", o_st, o_depth);
    end
  endtask

  task automatic test_mul();
    do_reset();
    send(4'd1, 16'd6);
    send(4'd1, 16'd7);
    send(4'd12, 16'h0);
`ifdef STACK_ALU_MUL_EN
    checks++;
    if ({o_st, o_top, o_depth, o_ovf} !== {3'b000, 16'd42, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL mul_en got st%b top%0d d%0d ov%b want 000 42 1 0",
               o_st, o_top, o_depth, o_ovf);
    end
`else
    checks++;
    if ({o_st, o_depth, o_top} !== {3'b100, 4'd2, 16'd7}) begin
      errors++;
      $display("FAIL mul_dis got st%b d%0d top%0d want 100 2 7",
               o_st, o_depth, o_top);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = 4'd1;
    cmd_imm   = 16'h00AA;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (rsp_valid) pulses++;
    end
    cmd_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (pulses != 4 || depth_w !== 4'd4) begin
      errors++;
      $display("FAIL back_to_back got pulses=%0d d%0d want 4 4", pulses, depth_w);
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    do_reset();
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = 4'd1;
    cmd_imm   = 16'h5555;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
      seen |= rsp_valid;
    end
    @(negedge CLK);
    reset = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      seen |= rsp_valid;
    end
    checks++;
    if ({seen, depth_w, empty_w, cmd_ready} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL abort got rv%b d%0d e%b rdy%b want 0 0 1 1",
               seen, depth_w, empty_w, cmd_ready);
    end
    m_q.delete();
    m_sticky = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] imm;
    logic [2:0]  est;
    logic        eov;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      op  = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      imm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) imm = 16'h7FFF + 16'($urandom_range(0, 2));
      send(op, imm);
      model(op, imm, est, eov);
      checks++;
      if ({o_rdy_x, o_rv_x, o_rv, o_rv_a, o_rdy_a} !== 5'b00101) begin
        errors++;
        $display("FAIL rnd_hs k=%0d op=%0d got %b want 00101", k, op,
                 {o_rdy_x, o_rv_x, o_rv, o_rv_a, o_rdy_a});
      end
      checks++;
      if ({o_st, o_ovf, o_st_a} !== {est, eov, est}) begin
        errors++;
        $display("FAIL rnd_status k=%0d op=%0d got st%b ov%b hold%b want %b %b",
                 k, op, o_st, o_ovf, o_st_a, est, eov);
      end
      checks++;
      if ({o_top, o_next} !== {m_top(), m_next()}) begin
        errors++;
        $display("FAIL rnd_data k=%0d op=%0d got %h/%h want %h/%h",
                 k, op, o_top, o_next, m_top(), m_next());
      end
      checks++;
      if ({o_depth, o_full, o_empty, o_stk} !==
          {4'(m_q.size()), m_q.size() == 8, m_q.size() == 0, m_sticky}) begin
        errors++;
        $display("FAIL rnd_depth k=%0d op=%0d got d%0d f%b e%b es%b want d%0d es%b",
                 k, op, o_depth, o_full, o_empty, o_stk, m_q.size(), m_sticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_ovf();
    test_full();
    test_underflow();
    test_mul();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
